issue_hazard_ctrl: RTL and testbench
====================================

ISSUE_HAZARD_CTRL -- requirements
Module: issue_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles the FLUSH state holds after a taken branch (legal range 1-15).
REQ-002 SHALL have parameter CNT_W, default 8, width of the saturating performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sb_ready  input  8  register scoreboard vector; bit i=1 means register i has no pending write.
REQ-006 SHALL have port de_valid  input  1  decode stage holds a valid instruction.
REQ-007 SHALL have ports de_uses_sr1/de_uses_sr2/de_uses_dest  input  1 each  operand-use flags.
REQ-008 SHALL have ports de_sr1/de_sr2/de_dest  input  3 each  lc3b_reg operand indices.
REQ-009 SHALL have port mem_miss  input  1  instruction or data cache miss in progress.
REQ-010 SHALL have port br_taken  input  1  taken branch resolved this cycle.
REQ-011 SHALL have port issue  output  1  decode instruction advances this cycle.
REQ-012 SHALL have port stall  output  1  decode must hold its instruction.
REQ-013 SHALL have port flush  output  1  squash younger pipeline contents.
REQ-014 SHALL have ports claim (output, 1) and claim_reg (output, 3)  scoreboard busy-mark request and register index.
REQ-015 SHALL have port hazard_reg  output  3  register that caused the latest hazard entry.
REQ-016 SHALL have ports stall_cycles and hazard_events  output  CNT_W each  performance counters.

Function
REQ-017 SHALL compute combinational hazard = de_valid & ((de_uses_sr1 & ~sb_ready[de_sr1]) | (de_uses_sr2 & ~sb_ready[de_sr2]) | (de_uses_dest & ~sb_ready[de_dest])), the last term covering WAW.
REQ-018 SHALL implement FSM states RUN, HAZARD, MISS, FLUSH; next state is resolved in priority order br_taken > mem_miss > per-state rule.
REQ-019 SHALL go to FLUSH from any state when br_taken=1, loading flush_cnt=FLUSH_CYCLES-1; a br_taken arriving while already in FLUSH reloads the count.
REQ-020 SHALL, when br_taken=0 and mem_miss=1, go to MISS from any state, including FLUSH, abandoning the remaining flush count.
REQ-021 SHALL, with neither event present: in FLUSH, decrement flush_cnt and go to RUN on the cycle flush_cnt=0; in MISS, go to RUN; in RUN or HAZARD, go to HAZARD if hazard=1, else RUN.
REQ-022 SHALL drive issue = de_valid & ~hazard & ~mem_miss & ~br_taken & (state==RUN | state==HAZARD), giving zero-cycle release the cycle a hazard clears.
REQ-023 SHALL drive stall = de_valid & ~issue.
REQ-024 SHALL drive flush = br_taken | (state==FLUSH).
REQ-025 SHALL drive claim = issue & de_uses_dest and claim_reg = de_dest; claim SHALL never assert while flush=1.
REQ-026 SHALL register hazard_reg on each RUN->HAZARD transition, selecting the first blocking operand in priority sr1, sr2, dest, and hold it otherwise.
REQ-027 SHALL increment stall_cycles each cycle stall=1 and hazard_events on each RUN->HAZARD transition; both saturate at 2^CNT_W-1 with no wrap.
REQ-028 SHALL treat a source equal to a dest of the same instruction using only the sb_ready value, with no self-forwarding.

Reset
REQ-029 SHALL, on a cycle with reset=1, set state=RUN, flush_cnt=0, hazard_reg=0, stall_cycles=0, hazard_events=0; reset overrides br_taken and mem_miss.
REQ-030 SHALL hold issue=0, claim=0, stall=0 and flush=0 during reset cycles regardless of inputs; reset mid-FLUSH or mid-MISS returns to RUN the next cycle.

Verification
REQ-031 SHALL cover no hazard: sb_ready=8'hFF, de_valid=1, sr1=2, sr2=3, dest=4 -> issue=1, claim=1, claim_reg=4, stall=0 every cycle.
REQ-032 SHALL cover RAW: sb_ready=8'hFB, uses_sr1 with sr1=2 for 3 cycles, then 8'hFF -> stall=1 for 3 cycles, hazard_reg=2, hazard_events=1, stall_cycles=3, issue=1 on cycle 4.
REQ-033 SHALL cover a branch: br_taken pulsed 1 cycle with FLUSH_CYCLES=2 -> flush=1 for 3 cycles (pulse plus 2 FLUSH), issue=0 throughout, then RUN.
REQ-034 SHALL cover a miss during flush: br_taken, then mem_miss=1 on the next cycle for 4 cycles -> MISS entered, flush drops, issue=0 for 4 cycles, then RUN.
REQ-035 SHALL cover saturation: CNT_W=4 with a 20-cycle hazard -> stall_cycles holds at 15.
REQ-036 SHALL cover reset during HAZARD with stall_cycles=5 -> after one reset cycle, state=RUN and stall_cycles=0.

Source files
------------

// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: decode-stage issue gate. Checks operand readiness
// against the register scoreboard, sequences branch flushes and cache-miss
// holds, and keeps saturating stall/hazard performance counters.
module issue_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       sb_ready,
  input  logic             de_valid,
  input  logic             de_uses_sr1,
  input  logic             de_uses_sr2,
  input  logic             de_uses_dest,
  input  logic [2:0]       de_sr1,
  input  logic [2:0]       de_sr2,
  input  logic [2:0]       de_dest,
  input  logic             mem_miss,
  input  logic             br_taken,
  output logic             issue,
  output logic             stall,
  output logic             flush,
  output logic             claim,
  output logic [2:0]       claim_reg,
  output logic [2:0]       hazard_reg,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] hazard_events
);

  typedef enum logic [1:0] {RUN, HAZARD, MISS, FLUSH} state_t;

  // Count loaded on a taken branch; FLUSH exits on the cycle it reads zero,
  // so the state is held for exactly FLUSH_CYCLES cycles.
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic       blk_sr1, blk_sr2, blk_dest;
  logic       hazard, enter_hazard, run_like;
  logic [2:0] first_blk;

  // A source that matches this instruction's own dest is judged purely on
  // the scoreboard bit; there is no self-forwarding path.
  assign blk_sr1  = de_uses_sr1  & ~sb_ready[de_sr1];
  assign blk_sr2  = de_uses_sr2  & ~sb_ready[de_sr2];
  assign blk_dest = de_uses_dest & ~sb_ready[de_dest];
  assign hazard   = de_valid & (blk_sr1 | blk_sr2 | blk_dest);

  // Next state: branch beats miss beats the per-state rule.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (br_taken) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
    end else if (mem_miss) begin
      state_nxt     = MISS;
      flush_cnt_nxt = '0;
    end else begin
      case (state)
        FLUSH: begin
          if (flush_cnt == 4'd0) state_nxt = RUN;
          else                   flush_cnt_nxt = flush_cnt - 4'd1;
        end
        MISS:    state_nxt = RUN;
        default: state_nxt = hazard ? HAZARD : RUN;
      endcase
    end
  end

  // Operand reported as the hazard cause: sr1, then sr2, then dest.
  always_comb begin
    first_blk = de_dest;
    if (blk_sr1)      first_blk = de_sr1;
    else if (blk_sr2) first_blk = de_sr2;
  end

  assign enter_hazard = (state == RUN) & (state_nxt == HAZARD);
  assign run_like     = (state == RUN) | (state == HAZARD);

  // Issue releases in the same cycle a hazard clears; reset masks all
  // pipeline controls regardless of the stored state.
  assign issue     = ~reset & de_valid & ~hazard & ~mem_miss & ~br_taken & run_like;
  assign stall     = ~reset & de_valid & ~issue;
  assign flush     = ~reset & (br_taken | (state == FLUSH));
  assign claim     = issue & de_uses_dest;
  assign claim_reg = de_dest;

  // State register and flush countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Hazard cause capture and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hazard_reg    <= '0;
      stall_cycles  <= '0;
      hazard_events <= '0;
    end else begin
      if (enter_hazard) hazard_reg <= first_blk;
      if (stall && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (enter_hazard && hazard_events != CNT_MAX)
        hazard_events <= hazard_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// tb_issue_hazard_ctrl: directed scenarios plus random traffic, every cycle
// compared against a cycle-level behavioural model of the issue rules.
module tb_issue_hazard_ctrl;

  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    sb_ready;
  logic          de_valid, de_uses_sr1, de_uses_sr2, de_uses_dest;
  logic [2:0]    de_sr1, de_sr2, de_dest;
  logic          mem_miss, br_taken;
  logic          issue, stall, flush, claim;
  logic [2:0]    claim_reg, hazard_reg;
  logic [CW-1:0] stall_cycles, hazard_events;

  int n_chk = 0;
  int n_err = 0;

  // Model: flush_left = FLUSH cycles still to serve, in_miss / in_haz flags.
  int m_flush_left = 0;
  bit m_miss = 0, m_haz = 0, m_known = 0;
  int m_stalls = 0, m_events = 0, m_hreg = 0;

  issue_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sb_ready(sb_ready), .de_valid(de_valid),
    .de_uses_sr1(de_uses_sr1), .de_uses_sr2(de_uses_sr2),
    .de_uses_dest(de_uses_dest), .de_sr1(de_sr1), .de_sr2(de_sr2),
    .de_dest(de_dest), .mem_miss(mem_miss), .br_taken(br_taken),
    .issue(issue), .stall(stall), .flush(flush), .claim(claim),
    .claim_reg(claim_reg), .hazard_reg(hazard_reg),
    .stall_cycles(stall_cycles), .hazard_events(hazard_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit rst, input logic [7:0] sb, input bit v,
                        input bit u1, input bit u2, input bit ud,
                        input int s1, input int s2, input int d,
                        input bit miss, input bit br);
    reset = rst; sb_ready = sb; de_valid = v;
    de_uses_sr1 = u1; de_uses_sr2 = u2; de_uses_dest = ud;
    de_sr1 = 3'(s1); de_sr2 = 3'(s2); de_dest = 3'(d);
    mem_miss = miss; br_taken = br;
  endtask

  // One cycle: check outputs against the model, advance the model, then
  // wait for the next falling edge where new inputs are applied.
  task automatic step();
    bit b1, b2, bd, hz, e_issue, e_stall, e_flush, in_run, in_issue_state;
    int blk;
    #1;
    b1 = de_uses_sr1  && !sb_ready[de_sr1];
    b2 = de_uses_sr2  && !sb_ready[de_sr2];
    bd = de_uses_dest && !sb_ready[de_dest];
    hz = de_valid && (b1 || b2 || bd);
    blk = b1 ? int'(de_sr1) : (b2 ? int'(de_sr2) : int'(de_dest));
    in_issue_state = !m_miss && (m_flush_left == 0);
    in_run = in_issue_state && !m_haz;
    if (reset) begin
      e_issue = 0; e_stall = 0; e_flush = 0;
    end else begin
      e_issue = de_valid && !hz && !mem_miss && !br_taken && in_issue_state;
      e_stall = de_valid && !e_issue;
      e_flush = br_taken || (m_flush_left > 0);
    end
    chk("issue", 32'(issue), 32'(e_issue));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("claim", 32'(claim), 32'(e_issue && de_uses_dest));
    chk("claim_reg", 32'(claim_reg), 32'(de_dest));
    if (m_known) begin
      chk("hazard_reg", 32'(hazard_reg), 32'(m_hreg));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
      chk("hazard_events", 32'(hazard_events), 32'(m_events));
    end
    if (reset) begin
      m_flush_left = 0; m_miss = 0; m_haz = 0;
      m_stalls = 0; m_events = 0; m_hreg = 0; m_known = 1;
    end else begin
      if (in_run && !br_taken && !mem_miss && hz) begin
        m_hreg = blk;
        if (m_events < CMAX) m_events++;
      end
      if (e_stall && m_stalls < CMAX) m_stalls++;
      if (br_taken) begin
        m_flush_left = FC; m_miss = 0; m_haz = 0;
      end else if (mem_miss) begin
        m_flush_left = 0; m_miss = 1; m_haz = 0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (m_miss) begin
        m_miss = 0;
      end else begin
        m_haz = hz;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(1, 8'hFF, 1, 1, 1, 1, 1, 2, 3, 1, 1);
    step();
  endtask

  initial begin
    set_in(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    chk("rst_stall_cycles", 32'(stall_cycles), 0);
    chk("rst_hazard_events", 32'(hazard_events), 0);
    chk("rst_hazard_reg", 32'(hazard_reg), 0);

    // No hazard: everything ready, issue and claim r4 each cycle.
    repeat (4) begin
      set_in(0, 8'hFF, 1, 1, 1, 1, 2, 3, 4, 0, 0);
      step();
    end

    // RAW on r2 for three cycles, then released.
    do_reset();
    repeat (3) begin
      set_in(0, 8'hFB, 1, 1, 0, 0, 2, 0, 5, 0, 0);
      step();
    end
    set_in(0, 8'hFF, 1, 1, 0, 0, 2, 0, 5, 0, 0);
    step();
    chk("raw_hazard_reg", 32'(hazard_reg), 2);
    chk("raw_hazard_events", 32'(hazard_events), 1);
    chk("raw_stall_cycles", 32'(stall_cycles), 3);

    // Taken branch pulse, then FLUSH drains back to RUN.
    set_in(0, 8'hFF, 1, 1, 1, 1, 1, 2, 3, 0, 1);
    step();
    repeat (4) begin
      set_in(0, 8'hFF, 1, 1, 1, 1, 1, 2, 3, 0, 0);
      step();
    end

    // Miss arriving during FLUSH abandons it.
    set_in(0, 8'hFF, 1, 1, 1, 1, 1, 2, 3, 0, 1);
    step();
    repeat (4) begin
      set_in(0, 8'hFF, 1, 1, 1, 1, 1, 2, 3, 1, 0);
      step();
    end
    repeat (2) begin
      set_in(0, 8'hFF, 1, 1, 1, 1, 1, 2, 3, 0, 0);
      step();
    end

    // Long hazard saturates the stall counter (WAW on r6).
    do_reset();
    repeat (20) begin
      set_in(0, 8'hBF, 1, 0, 0, 1, 0, 0, 6, 0, 0);
      step();
    end
    chk("sat_stall_cycles", 32'(stall_cycles), CMAX);
    chk("sat_hazard_reg", 32'(hazard_reg), 6);

    // Reset in the middle of a hazard.
    do_reset();
    repeat (5) begin
      set_in(0, 8'hF7, 1, 0, 1, 0, 0, 3, 1, 0, 0);
      step();
    end
    chk("pre_rst_stall_cycles", 32'(stall_cycles), 5);
    do_reset();
    chk("post_rst_stall_cycles", 32'(stall_cycles), 0);
    set_in(0, 8'hFF, 1, 0, 1, 0, 0, 3, 1, 0, 0);
    step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] sb;
      for (int b = 0; b < 8; b++) sb[b] = ($urandom_range(0, 99) < 80);
      set_in($urandom_range(0, 99) < 2, sb, $urandom_range(0, 99) < 85,
             1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)),
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
